// File: rtl/shared_tlb_miss_arbiter_if.sv
// Purpose : bundles the L1-TLB request side, shared-TLB lookup side and PTW side of the miss arbiter.
// Latency : none, wires only.
// Backpress: requesters hold *_req_i until their one-cycle *_gnt_o.
// Modports: slave  = the arbiter (consumes requests, drives grants/lookup/walk/completion)
//           master = the surrounding logic or bench (drives requests, hit, walk completion, flush)
// Optional: SHARED_TLB_ARB_PERF_EN adds lookup_cnt_o, hit_cnt_o, ptw_cnt_o (CNT_WIDTH bits).
interface shared_tlb_miss_arbiter_if #(
   parameter int VLEN = 39
`ifdef SHARED_TLB_ARB_PERF_EN
   , parameter int CNT_WIDTH = 32
`endif
);
   logic            flush_i;
   logic            itlb_req_i;
   logic [VLEN-1:0] itlb_vaddr_i;
   logic            itlb_gnt_o;
   logic            dtlb_req_i;
   logic [VLEN-1:0] dtlb_vaddr_i;
   logic            dtlb_gnt_o;
   logic            stlb_access_o;
   logic [VLEN-1:0] stlb_vaddr_o;
   logic            stlb_is_itlb_o;
   logic            stlb_hit_i;
   logic            ptw_req_o;
   logic [VLEN-1:0] ptw_vaddr_o;
   logic            ptw_is_itlb_o;
   logic            ptw_done_i;
   logic            ptw_error_i;
   logic            busy_o;
   logic            done_o;
   logic            done_itlb_o;
   logic            error_o;
`ifdef SHARED_TLB_ARB_PERF_EN
   logic [CNT_WIDTH-1:0] lookup_cnt_o;
   logic [CNT_WIDTH-1:0] hit_cnt_o;
   logic [CNT_WIDTH-1:0] ptw_cnt_o;
`endif

   modport slave (
      input  flush_i, itlb_req_i, itlb_vaddr_i, dtlb_req_i, dtlb_vaddr_i,
             stlb_hit_i, ptw_done_i, ptw_error_i,
      output itlb_gnt_o, dtlb_gnt_o, stlb_access_o, stlb_vaddr_o, stlb_is_itlb_o,
             ptw_req_o, ptw_vaddr_o, ptw_is_itlb_o, busy_o, done_o, done_itlb_o, error_o
`ifdef SHARED_TLB_ARB_PERF_EN
      , output lookup_cnt_o, hit_cnt_o, ptw_cnt_o
`endif
   );

   modport master (
      output flush_i, itlb_req_i, itlb_vaddr_i, dtlb_req_i, dtlb_vaddr_i,
             stlb_hit_i, ptw_done_i, ptw_error_i,
      input  itlb_gnt_o, dtlb_gnt_o, stlb_access_o, stlb_vaddr_o, stlb_is_itlb_o,
             ptw_req_o, ptw_vaddr_o, ptw_is_itlb_o, busy_o, done_o, done_itlb_o, error_o
`ifdef SHARED_TLB_ARB_PERF_EN
      , input lookup_cnt_o, hit_cnt_o, ptw_cnt_o
`endif
   );
endinterface

// File: rtl/shared_tlb_miss_arbiter.sv
// Purpose : serialises ITLB/DTLB misses into the shared TLB and, on a shared-TLB miss, the PTW;
//           DTLB has priority but the ITLB is granted after MAX_DTLB_STREAK back-to-back DTLB wins.
// Latency : grant at T -> done_o at T+3 on a shared-TLB hit; done_o one cycle after ptw_done_i on a miss.
// Backpress: one translation in flight; no grants while busy_o, requesters hold req until granted.
// Ports   : clk_i, rst_i (async, active-high) plus bus (shared_tlb_miss_arbiter_if.slave) carrying
//           the request/grant, shared-TLB lookup, PTW and completion signals.
// Optional: SHARED_TLB_ARB_PERF_EN adds wrapping lookup/hit/walk counters, cleared only by rst_i.
module shared_tlb_miss_arbiter #(
   parameter int VLEN            = 39,
   parameter int MAX_DTLB_STREAK = 4
`ifdef SHARED_TLB_ARB_PERF_EN
   , parameter int CNT_WIDTH     = 32
`endif
) (
   input logic                      clk_i,
   input logic                      rst_i,
   shared_tlb_miss_arbiter_if.slave bus
);
   localparam int SW = $clog2(MAX_DTLB_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DTLB_STREAK);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOOKUP = 3'd1;
   localparam logic [2:0] ST_CHECK  = 3'd2;
   localparam logic [2:0] ST_PTW    = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [SW-1:0]   streak_q;
   logic [VLEN-1:0] vaddr_q;
   logic            src_itlb_q;
   logic            err_q;
   logic            idle;
   logic            pick_itlb;
   logic            gnt_itlb;
   logic            gnt_dtlb;

   assign idle = (state_q == ST_IDLE);

   // ITLB wins a contended cycle only once the DTLB has used up its streak.
   assign pick_itlb = bus.itlb_req_i & (~bus.dtlb_req_i | (streak_q == STREAK_MAX));
   // Grants are combinational from the request; masked during flush and while reset is held.
   assign gnt_itlb  = idle & ~bus.flush_i & ~rst_i & pick_itlb;
   assign gnt_dtlb  = idle & ~bus.flush_i & ~rst_i & bus.dtlb_req_i & ~pick_itlb;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (gnt_itlb | gnt_dtlb) state_d = ST_LOOKUP;
         ST_LOOKUP: state_d = ST_CHECK;
         ST_CHECK:  state_d = bus.stlb_hit_i ? ST_DONE : ST_PTW;
         ST_PTW:    if (bus.ptw_done_i) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      // Flush overrides everything, including a coincident ptw_done_i.
      if (bus.flush_i) state_d = ST_IDLE;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         streak_q   <= '0;
         vaddr_q    <= '0;
         src_itlb_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (gnt_itlb | gnt_dtlb) begin
            vaddr_q    <= gnt_itlb ? bus.itlb_vaddr_i : bus.dtlb_vaddr_i;
            src_itlb_q <= gnt_itlb;
            err_q      <= 1'b0;
         end else if ((state_q == ST_PTW) && bus.ptw_done_i) begin
            err_q <= bus.ptw_error_i;
         end
         // Streak only measures DTLB wins while an ITLB request is actually waiting.
         if (bus.flush_i || !bus.itlb_req_i || gnt_itlb)
            streak_q <= '0;
         else if (gnt_dtlb && (streak_q != STREAK_MAX))
            streak_q <= streak_q + SW'(1);
      end
   end

   assign bus.itlb_gnt_o     = gnt_itlb;
   assign bus.dtlb_gnt_o     = gnt_dtlb;
   assign bus.stlb_access_o  = (state_q == ST_LOOKUP);
   assign bus.stlb_vaddr_o   = vaddr_q;
   assign bus.stlb_is_itlb_o = src_itlb_q;
   assign bus.ptw_req_o      = (state_q == ST_PTW);
   assign bus.ptw_vaddr_o    = vaddr_q;
   assign bus.ptw_is_itlb_o  = src_itlb_q;
   assign bus.busy_o         = ~idle;
   // A flush landing on the DONE cycle drops the completion as well.
   assign bus.done_o         = (state_q == ST_DONE) & ~bus.flush_i;
   assign bus.done_itlb_o    = bus.done_o & src_itlb_q;
   assign bus.error_o        = bus.done_o & err_q;

`ifdef SHARED_TLB_ARB_PERF_EN
   logic [CNT_WIDTH-1:0] lookup_cnt_q, hit_cnt_q, ptw_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lookup_cnt_q <= '0;
         hit_cnt_q    <= '0;
         ptw_cnt_q    <= '0;
      end else begin
         if (state_q == ST_LOOKUP)
            lookup_cnt_q <= lookup_cnt_q + CNT_WIDTH'(1);
         if ((state_q == ST_CHECK) && bus.stlb_hit_i)
            hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
         if ((state_q == ST_CHECK) && (state_d == ST_PTW))
            ptw_cnt_q <= ptw_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign bus.lookup_cnt_o = lookup_cnt_q;
   assign bus.hit_cnt_o    = hit_cnt_q;
   assign bus.ptw_cnt_o    = ptw_cnt_q;
`endif
endmodule

// File: tb/tb_shared_tlb_miss_arbiter.sv
// Purpose : checks shared_tlb_miss_arbiter against a transaction-age model with directed and random stimulus.
// Latency : n/a (bench).
// Backpress: bench requesters hold their request until the model predicts the grant.
module tb_shared_tlb_miss_arbiter;
   localparam int VLEN = 39;
   localparam int MAXS = 4;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   shared_tlb_miss_arbiter_if #(.VLEN(VLEN)) bus ();
   shared_tlb_miss_arbiter #(.VLEN(VLEN), .MAX_DTLB_STREAK(MAXS)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // requester state
   bit              it_req = 0, dt_req = 0;
   logic [VLEN-1:0] it_va = '0, dt_va = '0;

   // reference model: one outstanding translation tracked by its age since grant
   bit              m_busy = 0, m_fin = 0, m_ptw = 0, m_src = 0, m_err = 0;
   int              m_age = 0, m_streak = 0;
   logic [VLEN-1:0] m_va = '0;

   // observed-event log for directed checks
   bit       o_gi, o_gd, o_acc, o_ptw, o_done, o_busy, o_err, o_ditlb;
   int       last_gi_cyc = -1, last_acc_cyc = -1, last_done_cyc = -1, last_ptw_cyc = -1;
   int       ptw_cnt = 0, done_cnt = 0, n_gnt = 0;
   bit       last_done_itlb = 0, last_err = 0;
   logic [9:0] ord = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input bit f, input bit hit, input bit pd, input bit pe);
      bit e_acc, e_ptw, e_done, e_gi, e_gd;
      @(posedge clk_i); #1;
      bus.flush_i = f;       bus.stlb_hit_i = hit;
      bus.ptw_done_i = pd;   bus.ptw_error_i = pe;
      bus.itlb_req_i = it_req; bus.itlb_vaddr_i = it_va;
      bus.dtlb_req_i = dt_req; bus.dtlb_vaddr_i = dt_va;
      @(negedge clk_i);
      cyc++;
      e_acc  = m_busy && (m_age == 1);
      e_ptw  = m_busy && m_ptw;
      e_done = m_busy && m_fin && !f;
      e_gi = 0; e_gd = 0;
      if (!m_busy && !f) begin
         if (dt_req && !(it_req && m_streak == MAXS)) e_gd = 1;
         else if (it_req) e_gi = 1;
      end
      o_gi = bus.itlb_gnt_o; o_gd = bus.dtlb_gnt_o; o_acc = bus.stlb_access_o;
      o_ptw = bus.ptw_req_o; o_done = bus.done_o; o_busy = bus.busy_o;
      o_err = bus.error_o;   o_ditlb = bus.done_itlb_o;
      chk("itlb_gnt", 64'(o_gi), 64'(e_gi));
      chk("dtlb_gnt", 64'(o_gd), 64'(e_gd));
      chk("stlb_access", 64'(o_acc), 64'(e_acc));
      chk("ptw_req", 64'(o_ptw), 64'(e_ptw));
      chk("busy", 64'(o_busy), 64'(m_busy));
      chk("done", 64'(o_done), 64'(e_done));
      if (e_acc) begin
         chk("stlb_vaddr", 64'(bus.stlb_vaddr_o), 64'(m_va));
         chk("stlb_is_itlb", 64'(bus.stlb_is_itlb_o), 64'(m_src));
      end
      if (e_ptw) begin
         chk("ptw_vaddr", 64'(bus.ptw_vaddr_o), 64'(m_va));
         chk("ptw_is_itlb", 64'(bus.ptw_is_itlb_o), 64'(m_src));
      end
      if (e_done) begin
         chk("done_itlb", 64'(o_ditlb), 64'(m_src));
         chk("error", 64'(o_err), 64'(m_err));
      end
      // event log from the DUT side, used only by the directed literal checks
      if (o_gi) begin last_gi_cyc = cyc; ord = {ord[8:0], 1'b1}; n_gnt++; end
      if (o_gd) begin ord = {ord[8:0], 1'b0}; n_gnt++; end
      if (o_acc) last_acc_cyc = cyc;
      if (o_ptw) begin ptw_cnt++; last_ptw_cyc = cyc; end
      if (o_done) begin
         last_done_cyc = cyc; last_done_itlb = o_ditlb; last_err = o_err; done_cnt++;
      end
      // advance the model across the coming clock edge
      if (f) begin
         m_busy = 0;
      end else if (m_busy) begin
         if (m_fin) m_busy = 0;
         else if (m_age == 2) begin
            if (hit) m_fin = 1; else m_ptw = 1;
         end else if (m_ptw && pd) begin
            m_ptw = 0; m_fin = 1; m_err = pe;
         end
         m_age++;
      end else if (e_gi || e_gd) begin
         m_busy = 1; m_age = 1; m_fin = 0; m_ptw = 0; m_err = 0;
         m_src = e_gi; m_va = e_gi ? it_va : dt_va;
      end
      if (f || !it_req || e_gi) m_streak = 0;
      else if (e_gd && m_streak < MAXS) m_streak++;
      if (e_gi) it_req = 0;
      if (e_gd) dt_req = 0;
   endtask

   task automatic do_reset();
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("rst_itlb_gnt", 64'(bus.itlb_gnt_o), 64'd0);
      chk("rst_dtlb_gnt", 64'(bus.dtlb_gnt_o), 64'd0);
      chk("rst_access", 64'(bus.stlb_access_o), 64'd0);
      chk("rst_stlb_vaddr", 64'(bus.stlb_vaddr_o), 64'd0);
      chk("rst_stlb_is_itlb", 64'(bus.stlb_is_itlb_o), 64'd0);
      chk("rst_ptw_req", 64'(bus.ptw_req_o), 64'd0);
      chk("rst_ptw_vaddr", 64'(bus.ptw_vaddr_o), 64'd0);
      chk("rst_ptw_is_itlb", 64'(bus.ptw_is_itlb_o), 64'd0);
      chk("rst_busy", 64'(bus.busy_o), 64'd0);
      chk("rst_done", 64'(bus.done_o), 64'd0);
      chk("rst_done_itlb", 64'(bus.done_itlb_o), 64'd0);
      chk("rst_error", 64'(bus.error_o), 64'd0);
`ifdef SHARED_TLB_ARB_PERF_EN
      chk("rst_lookup_cnt", 64'(bus.lookup_cnt_o), 64'd0);
      chk("rst_hit_cnt", 64'(bus.hit_cnt_o), 64'd0);
      chk("rst_ptw_cnt", 64'(bus.ptw_cnt_o), 64'd0);
`endif
      m_busy = 0; m_fin = 0; m_ptw = 0; m_streak = 0; m_va = '0; m_src = 0;
      // release with requests masked so no grant slips in outside the model's view
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      bus.itlb_req_i = 0; bus.dtlb_req_i = 0; bus.flush_i = 0; bus.ptw_done_i = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      bus.flush_i = 0; bus.itlb_req_i = 0; bus.dtlb_req_i = 0; bus.stlb_hit_i = 0;
      bus.ptw_done_i = 0; bus.ptw_error_i = 0; bus.itlb_vaddr_i = '0; bus.dtlb_vaddr_i = '0;
      do_reset();

      // 1: ITLB hit, latency grant T, access T+1, done T+3
      it_req = 1; it_va = VLEN'(64'h0000_1000); t0 = cyc + 1;
      for (int k = 0; k < 6; k++) step(0, 1, 0, 0);
      chk("t1_gnt_cycle", 64'(last_gi_cyc), 64'(t0));
      chk("t1_access_lat", 64'(last_acc_cyc - last_gi_cyc), 64'd1);
      chk("t1_done_lat", 64'(last_done_cyc - last_gi_cyc), 64'd3);
      chk("t1_done_itlb", 64'(last_done_itlb), 64'd1);
      chk("t1_error", 64'(last_err), 64'd0);

      // 2: DTLB miss, walk completes on its 10th cycle
      dt_req = 1; dt_va = VLEN'(64'h40_2000); ptw_cnt = 0;
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
      for (int k = 1; k <= 10; k++) step(0, 0, k == 10, 0);
      for (int k = 0; k < 2; k++) step(0, 0, 0, 0);
      chk("t2_ptw_cycles", 64'(ptw_cnt), 64'd10);
      chk("t2_done_after_walk", 64'(last_done_cyc - last_ptw_cyc), 64'd1);
      chk("t2_done_itlb", 64'(last_done_itlb), 64'd0);

      // 3: both requesters saturated, all hits -> D,D,D,D,I,D,D,D,D,I
      it_req = 1; dt_req = 1; it_va = VLEN'($urandom()); dt_va = VLEN'($urandom());
      n_gnt = 0; ord = '0;
      for (int k = 0; k < 100 && n_gnt < 10; k++) begin
         step(0, 1, 0, 0);
         if (n_gnt < 10) begin
            if (!it_req) begin it_req = 1; it_va = VLEN'($urandom()); end
            if (!dt_req) begin dt_req = 1; dt_va = VLEN'($urandom()); end
         end
      end
      chk("t3_grant_count", 64'(n_gnt), 64'd10);
      chk("t3_grant_order", 64'(ord), 64'h021);
      for (int k = 0; k < 10; k++) step(0, 1, 0, 0);

      // 4: flush in PTW coincident with ptw_done, ITLB waiting
      dt_req = 1; dt_va = VLEN'(64'h1234_5000);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
      it_req = 1; it_va = VLEN'(64'h7000);
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      done_cnt = 0;
      step(1, 0, 1, 0);
      step(0, 1, 0, 0);
      chk("t4_no_done", 64'(o_done), 64'd0);
      chk("t4_idle_after_flush", 64'(o_busy), 64'd0);
      chk("t4_regrant", 64'(o_gi), 64'd1);
      for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
      chk("t4_single_done", 64'(done_cnt), 64'd1);
      chk("t4_done_itlb", 64'(last_done_itlb), 64'd1);

      // 5: walk fault reported, stray ptw_done in IDLE ignored
      dt_req = 1; dt_va = VLEN'(64'h9000);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
      step(0, 0, 1, 1);
      step(0, 0, 0, 0);
      chk("t5_done", 64'(o_done), 64'd1);
      chk("t5_error", 64'(o_err), 64'd1);
      step(0, 0, 1, 1);
      chk("t5_stray_busy", 64'(o_busy), 64'd0);
      step(0, 0, 1, 0);
      chk("t5_stray_done", 64'(o_done), 64'd0);
      chk("t5_stray_busy2", 64'(o_busy), 64'd0);

`ifdef SHARED_TLB_ARB_PERF_EN
      // 6: counters over one hit and two misses, then reset mid-walk
      do_reset();
      dt_req = 1; dt_va = VLEN'(64'hA000);
      for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
      dt_req = 1; dt_va = VLEN'(64'hB000);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
      step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
      dt_req = 1; dt_va = VLEN'(64'hC000);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 0);
      chk("t6_lookup_cnt", 64'(bus.lookup_cnt_o), 64'd3);
      chk("t6_hit_cnt", 64'(bus.hit_cnt_o), 64'd1);
      chk("t6_ptw_cnt", 64'(bus.ptw_cnt_o), 64'd2);
      do_reset();
`endif

      // random traffic with flushes, stray walk pulses and occasional resets
      for (int k = 0; k < 3000; k++) begin
         if (!it_req && ($urandom_range(3) == 0)) begin
            it_req = 1; it_va = VLEN'({$urandom(), $urandom()});
         end
         if (!dt_req && ($urandom_range(3) == 0)) begin
            dt_req = 1; dt_va = VLEN'({$urandom(), $urandom()});
         end
         if ($urandom_range(499) == 0) do_reset();
         else step($urandom_range(39) == 0, 1'($urandom()), $urandom_range(5) == 0, 1'($urandom()));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
